// File: rtl/vid_pkg.sv
// Shared definitions for the video pixel-fetch path.
// Bus command/length codes and the fetch FSM state type.
package vid_pkg;

  localparam logic [2:0] CMD_IDLE  = 3'b000;
  localparam logic [2:0] CMD_RD    = 3'b010;
  localparam logic [2:0] CMD_RDATA = 3'b011;

  localparam logic [1:0] LEN1 = 2'b00;
  localparam logic [1:0] LEN4 = 2'b10;

  localparam logic [1:0] REQ_NONE = 2'b00;
  localparam logic [1:0] REQ_BID  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    BID,
    ADDR,
    DATA,
    DONE
  } state_t;

endpackage

// File: rtl/vid_addr_gen.sv
// Frame-buffer walker: line/word pointers, fetch address,
// burst sizing and end-of-line / end-of-frame flags.
module vid_addr_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] base_address,
  input  logic [31:0] lineinc,
  input  logic [12:0] hsize,
  input  logic [12:0] vsize,
  input  logic        reload,
  input  logic        advance,
  input  logic        len4,
  output logic [31:0] fetch_addr,
  output logic        burst4,
  output logic        line_end,
  output logic        frame_end
);

  logic [31:0] line_ptr;
  logic [12:0] word_cnt;
  logic [12:0] line_cnt;
  logic [12:0] step;

  assign step       = len4 ? 13'd4 : 13'd1;
  assign fetch_addr = line_ptr + {17'b0, word_cnt, 2'b00};
  assign burst4     = (hsize - word_cnt) >= 13'd4;
  assign line_end   = (word_cnt + step) >= hsize;
  assign frame_end  = line_end
                   && ((line_cnt + 13'd1) >= vsize);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_ptr <= '0;
      word_cnt <= '0;
      line_cnt <= '0;
    end else if (reload) begin
      line_ptr <= base_address;
      word_cnt <= '0;
      line_cnt <= '0;
    end else if (advance) begin
      if (line_end) begin
        word_cnt <= '0;
        line_cnt <= line_cnt + 13'd1;
        line_ptr <= line_ptr + lineinc;
      end else begin
        word_cnt <= word_cnt + step;
      end
    end
  end

endmodule

// File: rtl/vid_fetch_sched.sv
// Pixel-fetch scheduler: bids for the bus when the colour
// FIFOs have room, reads pixel bursts and writes the FIFOs.
module vid_fetch_sched
  import vid_pkg::*;
#(
  parameter int         FIFO_DEPTH = 16,
  parameter logic [3:0] TARGET     = 4'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] base_address,
  input  logic [31:0] lineinc,
  input  logic [12:0] hsize,
  input  logic [12:0] vsize,
  input  logic        vstart,
  input  logic [4:0]  fifo_level,
  input  logic        selin,
  input  logic [2:0]  cmdin,
  input  logic [31:0] addrdatain,
  input  logic        ackin,
  output logic [1:0]  reqout,
  output logic [3:0]  reqtar,
  output logic [2:0]  cmdout,
  output logic [1:0]  lenout,
  output logic [31:0] addrdataout,
  output logic        fifo_wr,
  output logic [23:0] fifo_wdata,
  output logic        frame_done
);

  localparam logic [4:0] LVL_MAX = 5'(FIFO_DEPTH - 4);

  state_t      state;
  state_t      state_n;
  logic        en_q;
  logic        restart_pend;
  logic        len4_q;
  logic [1:0]  beat_cnt;
  logic        reload;
  logic [31:0] fetch_addr;
  logic        burst4;
  logic        line_end;
  logic        frame_end;
  logic        pad_unused;

  logic beat;
  logic restart;
  logic last_beat;
  logic busy;

  assign pad_unused = ^addrdatain[31:24];
  assign beat       = (state == DATA) && selin
                   && (cmdin == CMD_RDATA);
  assign restart    = vstart || (en && !en_q);
  assign last_beat  = beat
                   && (!len4_q || beat_cnt == 2'd3);
  assign busy       = (state == BID) || (state == ADDR)
                   || (state == DATA);

  vid_addr_gen u_addr_gen (
    .clk          (clk),
    .reset        (reset),
    .base_address (base_address),
    .lineinc      (lineinc),
    .hsize        (hsize),
    .vsize        (vsize),
    .reload       (reload),
    .advance      (last_beat),
    .len4         (len4_q),
    .fetch_addr   (fetch_addr),
    .burst4       (burst4),
    .line_end     (line_end),
    .frame_end    (frame_end)
  );

  always_comb begin
    state_n = state;
    reload  = 1'b0;
    unique case (state)
      IDLE: begin
        // Reload takes its own cycle so sizing sees fresh pointers
        if (restart || restart_pend)
          reload = 1'b1;
        else if (en && fifo_level <= LVL_MAX)
          state_n = BID;
      end
      BID: begin
        if (ackin)
          state_n = ADDR;
        else if (!en)
          state_n = IDLE;
      end
      ADDR: state_n = DATA;
      DATA: begin
        if (last_beat) begin
          unique case (1'b1)
            restart || restart_pend: state_n = IDLE;
            frame_end:               state_n = DONE;
            default:                 state_n = IDLE;
          endcase
        end
      end
      DONE: begin
        if (vstart) begin
          reload  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      en_q         <= 1'b0;
      restart_pend <= 1'b0;
      len4_q       <= 1'b0;
      beat_cnt     <= '0;
    end else begin
      state <= state_n;
      en_q  <= en;
      if (reload)
        restart_pend <= 1'b0;
      else if (restart && busy)
        restart_pend <= 1'b1;
      if (state == IDLE && state_n == BID)
        len4_q <= burst4;
      if (state != DATA)
        beat_cnt <= '0;
      else if (beat)
        beat_cnt <= beat_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reqout      <= REQ_NONE;
      reqtar      <= 4'h0;
      cmdout      <= CMD_IDLE;
      lenout      <= LEN1;
      addrdataout <= '0;
      fifo_wr     <= 1'b0;
      fifo_wdata  <= '0;
      frame_done  <= 1'b0;
    end else begin
      reqout      <= (state_n == BID) ? REQ_BID : REQ_NONE;
      reqtar      <= (state_n == BID) ? TARGET : 4'h0;
      cmdout      <= (state_n == ADDR) ? CMD_RD : CMD_IDLE;
      lenout      <= (state_n == ADDR && len4_q) ? LEN4 : LEN1;
      addrdataout <= (state_n == ADDR) ? fetch_addr : '0;
      fifo_wr     <= beat;
      fifo_wdata  <= beat ? addrdatain[23:0] : '0;
      frame_done  <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_vid_fetch_sched.sv
// Scoreboard bench for vid_fetch_sched: stimulus queues
// expected bursts/writes, a monitor pops and compares.
module tb_vid_fetch_sched;
  import vid_pkg::*;

  typedef struct {
    logic [31:0] a;
    logic [1:0]  l;
  } bexp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [31:0] base_address;
  logic [31:0] lineinc;
  logic [12:0] hsize;
  logic [12:0] vsize;
  logic        vstart;
  logic [4:0]  fifo_level;
  logic        selin;
  logic [2:0]  cmdin;
  logic [31:0] addrdatain;
  logic        ackin;
  logic [1:0]  reqout;
  logic [3:0]  reqtar;
  logic [2:0]  cmdout;
  logic [1:0]  lenout;
  logic [31:0] addrdataout;
  logic        fifo_wr;
  logic [23:0] fifo_wdata;
  logic        frame_done;

  bexp_t       bq[$];
  logic [23:0] wq[$];
  int          checks = 0;
  int          errors = 0;
  int          wr_count = 0;
  logic [23:0] dseed = 24'h102030;

  always #5 clk = ~clk;

  vid_fetch_sched #(.FIFO_DEPTH(16), .TARGET(4'h5)) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .base_address (base_address),
    .lineinc      (lineinc),
    .hsize        (hsize),
    .vsize        (vsize),
    .vstart       (vstart),
    .fifo_level   (fifo_level),
    .selin        (selin),
    .cmdin        (cmdin),
    .addrdatain   (addrdatain),
    .ackin        (ackin),
    .reqout       (reqout),
    .reqtar       (reqtar),
    .cmdout       (cmdout),
    .lenout       (lenout),
    .addrdataout  (addrdataout),
    .fifo_wr      (fifo_wr),
    .fifo_wdata   (fifo_wdata),
    .frame_done   (frame_done)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    bexp_t e;
    logic [23:0] w;
    #1;
    if (cmdout == CMD_RD) begin
      if (bq.size() == 0) begin
        chk("unexpected_burst", addrdataout, 32'hFFFFFFFF);
      end else begin
        e = bq.pop_front();
        chk("burst_addr", addrdataout, e.a);
        chk("burst_len", 32'(lenout), 32'(e.l));
      end
    end
    if (fifo_wr) begin
      wr_count++;
      if (wq.size() == 0) begin
        chk("unexpected_wr", 32'(fifo_wdata), 32'hFFFFFFFF);
      end else begin
        w = wq.pop_front();
        chk("fifo_wdata", 32'(fifo_wdata), 32'(w));
      end
    end
  end

  task automatic exp_burst(input logic [31:0] a,
                           input logic [1:0] l);
    bexp_t e;
    e.a = a;
    e.l = l;
    bq.push_back(e);
  endtask

  task automatic pulse_vstart();
    vstart = 1'b1;
    @(negedge clk);
    vstart = 1'b0;
  endtask

  task automatic serve(input int beats, input int ack_dly,
                       input int vs_beat, input int rst_beat);
    int n = 0;
    logic [23:0] d;
    while (reqout !== REQ_BID && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      chk("bid_timeout", 32'(reqout), 32'(REQ_BID));
      return;
    end
    for (int i = 0; i < ack_dly; i++) begin
      chk("grant_wait_req", 32'(reqout), 32'(REQ_BID));
      chk("grant_wait_tar", 32'(reqtar), 32'h5);
      chk("grant_wait_cmd", 32'(cmdout), 32'(CMD_IDLE));
      @(negedge clk);
    end
    ackin = 1'b1;
    @(negedge clk);
    ackin = 1'b0;
    chk("addr_phase", 32'(cmdout), 32'(CMD_RD));
    @(negedge clk);
    chk("addr_one_cycle", 32'(cmdout), 32'(CMD_IDLE));
    for (int i = 0; i < beats; i++) begin
      d = dseed;
      dseed = dseed + 24'h010101;
      selin = 1'b1;
      cmdin = CMD_RDATA;
      addrdatain = {8'hA5, d};
      vstart = (i == vs_beat);
      if (i == rst_beat) begin
        reset = 1'b1;
        selin = 1'b0;
        cmdin = CMD_IDLE;
        vstart = 1'b0;
        #1;
        chk("rst_reqout", 32'(reqout), 32'h0);
        chk("rst_cmdout", 32'(cmdout), 32'h0);
        chk("rst_fifo_wr", 32'(fifo_wr), 32'h0);
        chk("rst_wdata", 32'(fifo_wdata), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      wq.push_back(d);
      @(negedge clk);
    end
    selin = 1'b0;
    cmdin = CMD_IDLE;
    vstart = 1'b0;
  endtask

  initial begin
    int wr0;
    reset = 1'b1;
    en = 1'b0;
    base_address = '0;
    lineinc = '0;
    hsize = '0;
    vsize = '0;
    vstart = 1'b0;
    fifo_level = '0;
    selin = 1'b0;
    cmdin = CMD_IDLE;
    addrdatain = '0;
    ackin = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_reqout", 32'(reqout), 32'h0);
    chk("reset_reqtar", 32'(reqtar), 32'h0);
    chk("reset_cmdout", 32'(cmdout), 32'h0);
    chk("reset_lenout", 32'(lenout), 32'h0);
    chk("reset_addr", addrdataout, 32'h0);
    chk("reset_wr", 32'(fifo_wr), 32'h0);
    chk("reset_wdata", 32'(fifo_wdata), 32'h0);
    chk("reset_done", 32'(frame_done), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // basic two-line frame
    base_address = 32'h1000;
    lineinc = 32'h400;
    hsize = 13'd8;
    vsize = 13'd2;
    exp_burst(32'h1000, LEN4);
    exp_burst(32'h1010, LEN4);
    exp_burst(32'h1400, LEN4);
    exp_burst(32'h1410, LEN4);
    wr0 = wr_count;
    en = 1'b1;
    for (int b = 0; b < 4; b++) begin
      if (b == 3)
        chk("basic_not_done", 32'(frame_done), 32'h0);
      serve(4, 0, -1, -1);
    end
    chk("basic_done", 32'(frame_done), 32'h1);
    chk("basic_wr_count", 32'(wr_count - wr0), 32'd16);

    // tail bursts with hsize=6
    hsize = 13'd6;
    exp_burst(32'h1000, LEN4);
    exp_burst(32'h1010, LEN1);
    exp_burst(32'h1014, LEN1);
    exp_burst(32'h1400, LEN4);
    exp_burst(32'h1410, LEN1);
    exp_burst(32'h1414, LEN1);
    pulse_vstart();
    chk("tail_done_clr", 32'(frame_done), 32'h0);
    serve(4, 0, -1, -1);
    serve(1, 0, -1, -1);
    serve(1, 0, -1, -1);
    serve(4, 0, -1, -1);
    serve(1, 0, -1, -1);
    serve(1, 0, -1, -1);
    chk("tail_done", 32'(frame_done), 32'h1);

    // threshold then long grant wait
    hsize = 13'd8;
    fifo_level = 5'd13;
    pulse_vstart();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("thresh_no_bid", 32'(reqout), 32'h0);
    end
    exp_burst(32'h1000, LEN4);
    fifo_level = 5'd12;
    @(negedge clk);
    chk("thresh_bid", 32'(reqout), 32'(REQ_BID));
    serve(4, 10, -1, -1);
    fifo_level = 5'd0;

    // vstart during beat 2 restarts the frame
    exp_burst(32'h1010, LEN4);
    serve(4, 0, -1, -1);
    exp_burst(32'h1400, LEN4);
    serve(4, 0, 1, -1);
    exp_burst(32'h1000, LEN4);
    exp_burst(32'h1010, LEN4);
    exp_burst(32'h1400, LEN4);
    serve(4, 0, -1, -1);
    serve(4, 0, -1, -1);
    serve(4, 0, -1, -1);
    chk("restart_not_done", 32'(frame_done), 32'h0);
    exp_burst(32'h1410, LEN4);
    serve(4, 0, -1, -1);
    chk("restart_done", 32'(frame_done), 32'h1);

    // reset in the middle of a burst
    pulse_vstart();
    exp_burst(32'h1000, LEN4);
    serve(4, 0, -1, 2);
    exp_burst(32'h1000, LEN4);
    serve(4, 0, -1, -1);

    repeat (4) @(negedge clk);
    chk("burst_q_empty", 32'(bq.size()), 32'h0);
    chk("wr_q_empty", 32'(wq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
